// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory load/store path.
// Size codes, FSM state enum and default data-memory base address.
package mips_mem_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract (with zero/sign extension) and sub-word store merge.
// Purely combinational; no latency, no flow control.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[{addr_lo, 3'b000} +: 8];
    half_val = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (size)
      SIZE_BYTE: begin
        load_val = {{24{is_signed & byte_val[7]}}, byte_val};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_val = {{16{is_signed & half_val[15]}}, half_val};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: loads 2 cycles, word stores 2, sub-word stores 3 (RMW), errors 1.
// Single outstanding request; req_ready is high only in IDLE.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // 33-bit bounds so a region ending at 4 GiB does not wrap.
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + (33'(DEPTH_WORDS) << 2);

  lsu_state_t  state, state_nxt;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  size_q;
  logic        signed_q, write_q, err_q;
  logic        req_err, accept;
  logic [31:0] align_word, load_val, merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_HALF:    req_err = req_addr[0];
      SIZE_WORD:    req_err = (req_addr[1:0] != 2'b00);
      SIZE_ILLEGAL: req_err = 1'b1;
      default:      ;
    endcase
    if ({1'b0, req_addr} < LO_ADDR || {1'b0, req_addr} >= HI_ADDR)
      req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                  state_nxt = RESP;
          else if (!req_write)          state_nxt = LOAD;
          else if (req_size == SIZE_WORD) state_nxt = WRITE;
          else                          state_nxt = RMW_READ;
        end
      end
      LOAD:      state_nxt = RESP;
      WRITE:     state_nxt = RESP;
      RMW_READ:  state_nxt = RMW_WRITE;
      RMW_WRITE: state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
        err_q    <= req_err;
        data_q   <= '0;
      end else if (state == LOAD) begin
        data_q <= load_val;
      end else if (state == RMW_READ) begin
        data_q <= mem_read_data;
      end
    end
  end

  // During RMW_WRITE the merge works on the word captured in RMW_READ.
  assign align_word = (state == RMW_WRITE) ? data_q : mem_read_data;

  lsu_lane_align u_lane_align (
    .word      (align_word),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .merged    (merged)
  );

  assign req_ready      = (state == IDLE);
  assign mem_read       = (state == LOAD) || (state == RMW_READ);
  assign mem_write      = (state == WRITE) || (state == RMW_WRITE);
  assign mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_write_data = (state == WRITE)     ? wdata_q :
                          (state == RMW_WRITE) ? merged  : 32'h0;
  assign resp_valid     = (state == RESP);
  assign resp_err       = resp_valid && err_q;
  assign resp_rdata     = (resp_valid && !write_q && !err_q) ? data_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, RMW, loads, errors, back-to-back, reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Presents one request for one accepting edge; returns at the negedge of cycle T+1.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %0b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %0b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp got err=%0b rdata=%h want 0/0", resp_err, resp_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_en got rd=%0b wr=%0b want 0/0", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h0 || mem_write_data !== 32'h0) begin fails++; $display("FAIL rst_mem_bus got addr=%h data=%h want 0/0", mem_address, mem_write_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF);
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("FAIL ws_en got rd=%0b wr=%0b want 0/1", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h1001_0008) begin fails++; $display("FAIL ws_addr got %h want 10010008", mem_address); end
    checks++; if (mem_write_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ws_data got %h want deadbeef", mem_write_data); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL ws_t1_hs got rdy=%0b rv=%0b want 0/0", req_ready, resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL ws_resp got rv=%0b err=%0b rdata=%h want 1/0/0", resp_valid, resp_err, resp_rdata); end
    checks++; if (mem_write !== 1'b0 || mem_address !== 32'h0) begin fails++; $display("FAIL ws_resp_mem got wr=%0b addr=%h want 0/0", mem_write, mem_address); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL ws_idle got rdy=%0b rv=%0b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_rmw_store();
    logic [31:0] addrs [2] = '{32'h1001_0009, 32'h1001_000A};
    logic [1:0]  sizes [2] = '{2'b00, 2'b01};
    logic [31:0] wdat  [2] = '{32'h5555_55AA, 32'h1234_BEEF};
    logic [31:0] exp   [2] = '{32'h1122_AA44, 32'hBEEF_3344};
    for (int i = 0; i < 2; i++) begin
      mem_read_data = 32'h1122_3344;
      issue(1'b1, sizes[i], 1'b0, addrs[i], wdat[i]);
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL rmw%0d_rd got rd=%0b wr=%0b want 1/0", i, mem_read, mem_write); end
      checks++; if (mem_address !== 32'h1001_0008) begin fails++; $display("FAIL rmw%0d_rd_addr got %h want 10010008", i, mem_address); end
      @(negedge clk);
      mem_read_data = 32'hFFFF_FFFF;
      #1;
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("FAIL rmw%0d_wr got rd=%0b wr=%0b want 0/1", i, mem_read, mem_write); end
      checks++; if (mem_write_data !== exp[i]) begin fails++; $display("FAIL rmw%0d_data got %h want %h", i, mem_write_data, exp[i]); end
      checks++; if (mem_address !== 32'h1001_0008) begin fails++; $display("FAIL rmw%0d_wr_addr got %h want 10010008", i, mem_address); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL rmw%0d_resp got rv=%0b err=%0b rdata=%h want 1/0/0", i, resp_valid, resp_err, resp_rdata); end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    logic [31:0] addrs [5] = '{32'h1001_000B, 32'h1001_000B, 32'h1001_000A, 32'h1001_0008, 32'h1001_0008};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        sgn   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp   [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0000, 32'h80FF_0000};
    for (int i = 0; i < 5; i++) begin
      mem_read_data = 32'h80FF_0000;
      issue(1'b0, sizes[i], sgn[i], addrs[i], 32'h0);
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h1001_0008) begin fails++; $display("FAIL ld%0d_rd got rd=%0b addr=%h want 1/10010008", i, mem_read, mem_address); end
      @(negedge clk);
      mem_read_data = 32'h1234_5678;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp[i] || resp_err !== 1'b0) begin fails++; $display("FAIL ld%0d_resp got rv=%0b rdata=%h err=%0b want 1/%h/0", i, resp_valid, resp_rdata, resp_err, exp[i]); end
      checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL ld%0d_rd_off got %0b want 0", i, mem_read); end
      @(negedge clk);
      checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL ld%0d_rdata_idle got %h want 0", i, resp_rdata); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6] = '{32'h1001_0001, 32'h1000_FFFC, 32'h1001_0000, 32'h1001_0002, 32'h1001_4000, 32'h0000_0000};
    logic [1:0]  sizes [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
    logic        wrs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      mem_read_data = 32'hCAFE_F00D;
      issue(wrs[i], sizes[i], 1'b1, addrs[i], 32'hFFFF_FFFF);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin fails++; $display("FAIL err%0d_resp got rv=%0b err=%0b rdata=%h want 1/1/0", i, resp_valid, resp_err, resp_rdata); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL err%0d_mem got rd=%0b wr=%0b want 0/0", i, mem_read, mem_write); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL err%0d_after got rv=%0b err=%0b rd=%0b wr=%0b want 0/0/0/0", i, resp_valid, resp_err, mem_read, mem_write); end
    end
    // Last byte of the region is legal; one past it was checked above.
    mem_read_data = 32'hAB00_0000;
    issue(1'b0, 2'b00, 1'b0, 32'h1001_3FFF, 32'h0);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h1001_3FFC) begin fails++; $display("FAIL top_rd got rd=%0b addr=%h want 1/10013ffc", mem_read, mem_address); end
    @(negedge clk);
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0000_00AB) begin fails++; $display("FAIL top_resp got err=%0b rdata=%h want 0/000000ab", resp_err, resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 32'h1001_0000; req_wdata = '0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL b2b_resp1 got rv=%0b rdy=%0b want 1/0", resp_valid, req_ready); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got rv=%0b rdy=%0b want 0/1", resp_valid, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin fails++; $display("FAIL b2b_resp2 got rv=%0b err=%0b want 1/1", resp_valid, resp_err); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got rv=%0b want 0", resp_valid); end
  endtask

  task automatic test_reset_mid_rmw();
    mem_read_data = 32'h1122_3344;
    issue(1'b1, 2'b00, 1'b0, 32'h1001_0009, 32'h0000_00AA);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("FAIL abort_in_rmw got rd=%0b want 1", mem_read); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL abort_now got rd=%0b wr=%0b rdy=%0b want 0/0/1", mem_read, mem_write, req_ready); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL abort_hold got wr=%0b rv=%0b want 0/0", mem_write, resp_valid); end
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL abort_after got wr=%0b rv=%0b rdy=%0b want 0/0/1", mem_write, resp_valid, req_ready); end
    end
    test_word_store();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_rmw_store();
    test_load();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of data-memory word 0.
REQ-002 Parameter DEPTH_WORDS, default 4096, data-memory depth in 32-bit words.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; these ports SHALL be listed first.
REQ-004 The block SHALL provide the following ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits for sub-word)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  misaligned/out-of-range/illegal size
- mem_read  out  1  data-memory read enable
- mem_write  out  1  data-memory write enable
- mem_address  out  32  word-aligned byte address to memory
- mem_write_data  out  32  full word to memory
- mem_read_data  in  32  combinational memory read data

Function
REQ-005 FSM states SHALL be: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with req_valid&&req_ready, and all request fields are registered on that edge.
REQ-007 Error SHALL be flagged when: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr<BASE_ADDR; addr>=BASE_ADDR+4*DEPTH_WORDS.
REQ-008 On an errored request the FSM SHALL go IDLE->RESP: resp_err=1, no mem_read/mem_write asserted, resp_valid one cycle after acceptance.
REQ-009 On a load the FSM SHALL go IDLE->LOAD->RESP: mem_read=1 during LOAD; resp_rdata is captured at the end of LOAD; resp_valid two cycles after acceptance.
REQ-010 On a word store the FSM SHALL go IDLE->WRITE->RESP: mem_write=1 with mem_write_data=req_wdata during WRITE.
REQ-011 On a byte/half store the FSM SHALL go IDLE->RMW_READ->RMW_WRITE->RESP: the word is read in RMW_READ and registered, then the selected lanes are merged and written in RMW_WRITE; resp_valid three cycles after acceptance.
REQ-012 Byte lanes SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-013 Sub-word loads SHALL zero-extend when req_signed=0 and sign-extend from bit 7/15 when req_signed=1; req_signed SHALL be ignored for word loads.
REQ-014 mem_address SHALL be {addr[31:2],2'b00} whenever mem_read or mem_write is 1, and 0 otherwise.
REQ-015 mem_read, mem_write and mem_address SHALL be decoded from the registered state only, never from req_* inputs directly.
REQ-016 RESP SHALL last exactly one cycle, with resp_valid=1, then return to IDLE; resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-017 A request presented while RESP is active SHALL NOT be accepted; it is accepted in the following IDLE cycle at the earliest.
REQ-018 mem_read and mem_write SHALL never be 1 in the same cycle.

Reset
REQ-019 While rst_n=0 the state SHALL be IDLE, all outputs SHALL be 0 except req_ready=1, and all request and data registers SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL immediately deassert mem_write/mem_read; the in-flight request SHALL be dropped with no resp_valid, and no partial merged write SHALL occur.

Structure
REQ-021 Shared package mips_mem_pkg SHALL hold the size encodings, the state enum and the BASE_ADDR default.
REQ-022 Lane extract/merge logic SHALL be a combinational sub-module, lsu_lane_align (inputs: word, addr[1:0], size, signed, wdata; outputs: load value, merged word).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Word store 0xDEADBEEF to 0x10010008 -> mem_write at T+1, addr 0x10010008; resp_valid at T+2, err=0.
- Byte store 0xAA to 0x10010009 over word 0x11223344 -> mem_read at T+1; mem_write at T+2 with 0x1122AA44; resp at T+3.
- Signed byte load from 0x1001000B of word 0x80FF0000 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Half load at 0x10010001, word at 0x1000FFFC, size=11 -> resp_err=1 at T+1, no memory enable ever asserted.
- rst_n pulled low during RMW_READ -> no mem_write, no resp_valid, req_ready=1; next request completes normally.
